rate_detector: RTL and testbench

//  Inverse of the rate divider: watches a pulse train (e.g. a divider Enable) and recovers
//  the 2-bit Speed code that produced it, by measuring the cycle count between pulses.

---
 rtl/rate_detector_pkg.sv | 25 ++
 rtl/rate_detector_classifier.sv | 49 ++++
 rtl/rate_detector.sv | 135 +++++++++++++
 tb/tb_rate_detector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rate_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rate_pkg
//  Description : Shared types, FSM state codes and the gap-limit helper for
//                the rate detector.
//  Revision    : 1.0  initial release
// ============================================================================
package rate_pkg;

    typedef logic [1:0] speed_t;
    typedef logic [1:0] state_t;

    // FSM state codes
    localparam state_t c_st_idle    = 2'd0;
    localparam state_t c_st_first   = 2'd1;
    localparam state_t c_st_confirm = 2'd2;
    localparam state_t c_st_locked  = 2'd3;

    // Longest quiet stretch (in counter steps) tolerated before a stall is flagged
    function automatic int max_gap(input int cf, input int tol);
        return 4 * cf + tol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rate_detector_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : rate_interval_classifier
//  Description : Maps a measured pulse interval onto the Speed code whose
//                period it matches within +/- TOLERANCE cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module rate_interval_classifier
    import rate_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int TOLERANCE       = 2,
    parameter int IW              = 12
) (
    input  logic [IW-1:0] interval,
    output logic [1:0]    speed_class,
    output logic          class_valid
);

    // Acceptance windows; lower bounds stay positive because CF > 2*TOL+1
    localparam logic [IW-1:0] c_one  = IW'(1);
    localparam logic [IW-1:0] c_lo_1 = IW'(CLOCK_FREQUENCY - TOLERANCE);
    localparam logic [IW-1:0] c_hi_1 = IW'(CLOCK_FREQUENCY + TOLERANCE);
    localparam logic [IW-1:0] c_lo_2 = IW'(2 * CLOCK_FREQUENCY - TOLERANCE);
    localparam logic [IW-1:0] c_hi_2 = IW'(2 * CLOCK_FREQUENCY + TOLERANCE);
    localparam logic [IW-1:0] c_lo_3 = IW'(4 * CLOCK_FREQUENCY - TOLERANCE);
    localparam logic [IW-1:0] c_hi_3 = IW'(4 * CLOCK_FREQUENCY + TOLERANCE);

    // Window match; the windows never overlap so priority order is irrelevant
    always_comb begin
        speed_class = 2'b00;
        class_valid = 1'b0;
        if (interval == c_one) begin
            speed_class = 2'b00;
            class_valid = 1'b1;
        end else if (interval >= c_lo_1 && interval <= c_hi_1) begin
            speed_class = 2'b01;
            class_valid = 1'b1;
        end else if (interval >= c_lo_2 && interval <= c_hi_2) begin
            speed_class = 2'b10;
            class_valid = 1'b1;
        end else if (interval >= c_lo_3 && interval <= c_hi_3) begin
            speed_class = 2'b11;
            class_valid = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rate_detector.sv
`default_nettype none
// ============================================================================
//  Module      : rate_detector
//  Description : Recovers the rate-divider Speed code from a pulse train by
//                timing the gaps between pulses; flags lock and stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module rate_detector
    import rate_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int TOLERANCE       = 2
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic       PulseIn,
    output logic [1:0] Speed,
    output logic       Locked,
    output logic       SpeedChange,
    output logic       Timeout
);

    localparam int c_max_gap = max_gap(CLOCK_FREQUENCY, TOLERANCE);
    localparam int CW        = $clog2(c_max_gap + 1);
    // One extra bit so count+1 cannot wrap at saturation
    localparam int IW        = CW + 1;
    localparam logic [CW-1:0] c_max_cnt = CW'(c_max_gap);

    logic [CW-1:0] r_count;
    state_t        r_state;
    speed_t        r_candidate;
    speed_t        r_speed;
    logic          r_speed_change;
    logic          r_timeout;

    logic [IW-1:0] w_interval;
    logic [1:0]    w_class;
    logic          w_valid;
    logic          w_gap_expired;

    assign w_interval    = {1'b0, r_count} + IW'(1);
    assign w_gap_expired = (r_count == c_max_cnt);

    rate_interval_classifier #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
        .TOLERANCE       (TOLERANCE),
        .IW              (IW)
    ) u_classifier (
        .interval    (w_interval),
        .speed_class (w_class),
        .class_valid (w_valid)
    );

    // Cycles since the last pulse, saturating so a dead input stays detectable
    always_ff @(posedge ClockIn) begin
        if (!Resetn) begin
            r_count <= '0;
        end else if (PulseIn) begin
            r_count <= '0;
        end else if (r_count != c_max_cnt) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Lock FSM: two consecutive matching intervals are required to lock
    always_ff @(posedge ClockIn) begin
        if (!Resetn) begin
            r_state        <= c_st_idle;
            r_candidate    <= 2'b00;
            r_speed        <= 2'b00;
            r_speed_change <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_speed_change <= 1'b0;
            r_timeout      <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (PulseIn) begin
                        r_state <= c_st_first;
                    end
                end
                c_st_first: begin
                    if (PulseIn) begin
                        if (w_valid) begin
                            r_state     <= c_st_confirm;
                            r_candidate <= w_class;
                        end
                    end else if (w_gap_expired) begin
                        r_state   <= c_st_idle;
                        r_timeout <= 1'b1;
                    end
                end
                c_st_confirm: begin
                    if (PulseIn) begin
                        if (!w_valid) begin
                            r_state <= c_st_first;
                        end else if (w_class == r_candidate) begin
                            r_state        <= c_st_locked;
                            r_speed        <= r_candidate;
                            r_speed_change <= 1'b1;
                        end else begin
                            r_candidate <= w_class;
                        end
                    end else if (w_gap_expired) begin
                        r_state   <= c_st_idle;
                        r_timeout <= 1'b1;
                    end
                end
                c_st_locked: begin
                    if (PulseIn) begin
                        if (!w_valid) begin
                            r_state <= c_st_first;
                        end else if (w_class != r_speed) begin
                            r_state     <= c_st_confirm;
                            r_candidate <= w_class;
                        end
                    end else if (w_gap_expired) begin
                        r_state   <= c_st_idle;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign Speed       = r_speed;
    assign Locked      = (r_state == c_st_locked);
    assign SpeedChange = r_speed_change;
    assign Timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rate_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rate_detector
//  Description : Self-checking bench for rate_detector (CF=20, TOL=2) with a
//                timestamp-based reference model and randomized pulse trains.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rate_detector;

    localparam int CF   = 20;
    localparam int TOL  = 2;
    localparam int MAXG = 4 * CF + TOL;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       pulse = 1'b0;
    logic [1:0] speed;
    logic       locked;
    logic       sc;
    logic       to;

    int tests = 0;
    int fails = 0;

    rate_detector #(
        .CLOCK_FREQUENCY (CF),
        .TOLERANCE       (TOL)
    ) dut (
        .ClockIn     (clk),
        .Resetn      (rstn),
        .PulseIn     (pulse),
        .Speed       (speed),
        .Locked      (locked),
        .SpeedChange (sc),
        .Timeout     (to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timestamps, not counters) ----------
    // progress: 0 = no reference pulse yet, 1 = have a reference pulse,
    //           2 = one good interval seen, 3 = locked
    int progress = 0;
    int cand     = 0;
    int m_speed  = 0;
    int last_t   = 0;
    int now_t    = 0;
    bit m_sc     = 1'b0;
    bit m_to     = 1'b0;
    bit m_valid  = 1'b0;

    function automatic int classify(input int iv);
        int d1, d2, d4;
        d1 = (iv > CF)     ? iv - CF     : CF - iv;
        d2 = (iv > 2 * CF) ? iv - 2 * CF : 2 * CF - iv;
        d4 = (iv > 4 * CF) ? iv - 4 * CF : 4 * CF - iv;
        if (iv == 1)   return 0;
        if (d1 <= TOL) return 1;
        if (d2 <= TOL) return 2;
        if (d4 <= TOL) return 3;
        return -1;
    endfunction

    always @(posedge clk) begin
        int cls;
        bit p;
        bit r;
        p = pulse;
        r = rstn;
        now_t++;
        if (!r) begin
            m_valid  = 1'b1;
            progress = 0;
            cand     = 0;
            m_speed  = 0;
            m_sc     = 1'b0;
            m_to     = 1'b0;
        end else if (m_valid) begin
            m_sc = 1'b0;
            m_to = 1'b0;
            if (p) begin
                cls    = classify(now_t - last_t);
                last_t = now_t;
                if (progress == 0 || cls < 0) begin
                    progress = 1;
                end else if (progress == 1) begin
                    progress = 2;
                    cand     = cls;
                end else if (progress == 2) begin
                    if (cls == cand) begin
                        progress = 3;
                        m_speed  = cls;
                        m_sc     = 1'b1;
                    end else begin
                        cand = cls;
                    end
                end else if (cls != m_speed) begin
                    progress = 2;
                    cand     = cls;
                end
            end else if (progress != 0 && (now_t - last_t) == MAXG + 1) begin
                progress = 0;
                m_to     = 1'b1;
            end
        end
        #1;
        if (m_valid) begin
            chk("speed",       {2'b00, speed}, 4'(m_speed));
            chk("locked",      {3'b000, locked}, {3'b000, progress == 3});
            chk("speedchange", {3'b000, sc}, {3'b000, m_sc});
            chk("timeout",     {3'b000, to}, {3'b000, m_to});
            chk("strobe_excl", {3'b000, sc & to}, 4'd0);
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic step(input bit p, input bit r = 1'b1);
        @(negedge clk);
        pulse = p;
        rstn  = r;
        @(posedge clk);
        #2;
    endtask

    // Pulse n sampling edges after the previous pulse
    task automatic pulse_period(input int n);
        repeat (n - 1) step(1'b0);
        step(1'b1);
    endtask

    task automatic low(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic chk_all(input string name, input logic [1:0] s, input bit l,
                           input bit c, input bit t);
        chk({name, "_speed"},  {2'b00, speed},  {2'b00, s});
        chk({name, "_locked"}, {3'b000, locked}, {3'b000, l});
        chk({name, "_sc"},     {3'b000, sc},     {3'b000, c});
        chk({name, "_to"},     {3'b000, to},     {3'b000, t});
    endtask

    initial begin
        int n;
        int base;
        int reps;

        // 1: reset held while the input toggles
        step(1'b1, 1'b0); chk_all("rst1", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0); chk_all("rst2", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0); chk_all("rst3", 2'b00, 1'b0, 1'b0, 1'b0);

        // 2: lock at period 40 after three pulses
        pulse_period(40);
        pulse_period(40); chk_all("p40_2", 2'b00, 1'b0, 1'b0, 1'b0);
        pulse_period(40); chk_all("p40_3", 2'b10, 1'b1, 1'b1, 1'b0);
        step(1'b0);       chk_all("p40_after", 2'b10, 1'b1, 1'b0, 1'b0);

        // 3: lock at 80, then tolerance edges 82 and 78
        pulse_period(79);
        pulse_period(80); chk_all("p80_lock", 2'b11, 1'b1, 1'b1, 1'b0);
        pulse_period(82); chk_all("p80_hi", 2'b11, 1'b1, 1'b0, 1'b0);
        pulse_period(78); chk_all("p80_lo", 2'b11, 1'b1, 1'b0, 1'b0);

        // 4: lock at 20, stall, relock
        pulse_period(20);
        pulse_period(20); chk_all("p20_lock", 2'b01, 1'b1, 1'b1, 1'b0);
        pulse_period(20);
        low(82);          chk_all("gap82", 2'b01, 1'b1, 1'b0, 1'b0);
        low(1);           chk_all("gap83", 2'b01, 1'b0, 1'b0, 1'b1);
        low(1);           chk_all("gap84", 2'b01, 1'b0, 1'b0, 1'b0);
        pulse_period(20);
        pulse_period(20);
        pulse_period(20); chk_all("relock", 2'b01, 1'b1, 1'b1, 1'b0);

        // 5: invalid period never locks; held-high input locks at 00
        for (int i = 0; i < 10; i++) begin
            pulse_period(30);
            chk("p30_unlocked", {3'b000, locked}, 4'd0);
        end
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);       chk_all("held", 2'b00, 1'b1, 1'b1, 1'b0);

        // 6: switch 01 -> 10, then reset mid-CONFIRM
        pulse_period(20);
        pulse_period(20); chk_all("s6_lock1", 2'b01, 1'b1, 1'b1, 1'b0);
        pulse_period(40); chk_all("s6_drop", 2'b01, 1'b0, 1'b0, 1'b0);
        pulse_period(40); chk_all("s6_lock2", 2'b10, 1'b1, 1'b1, 1'b0);
        pulse_period(20); chk_all("s6_conf", 2'b10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0); chk_all("s6_rst", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Randomized pulse trains checked cycle-by-cycle against the model
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 9))
                0: n = $urandom_range(1, 90);
                1: begin
                    step(1'b0, 1'b0);
                    n = $urandom_range(1, 40);
                end
                2: n = MAXG + 1 + $urandom_range(0, 3);
                default: begin
                    case ($urandom_range(0, 3))
                        0: base = 1;
                        1: base = CF;
                        2: base = 2 * CF;
                        default: base = 4 * CF;
                    endcase
                    n = (base == 1) ? 1 : base + $urandom_range(0, 6) - 3;
                end
            endcase
            reps = $urandom_range(1, 4);
            repeat (reps) pulse_period(n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
